divide: RTL and testbench



---
 rtl/divide.sv | 199 +++++++++++++++++++
 tb/tb_divide.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/divide.sv
// divide: sequential 16-bit restoring divider, one quotient bit per clock.
// Handles unsigned and two's-complement signed operands under a
// start/busy/done handshake; divide-by-zero and signed overflow short-cut
// straight to DONE without iterating.
module divide (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_mode,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic        overflow
);

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // Datapath registers
    logic [W-1:0]  r_dvd;     // dividend magnitude, quotient bits shift in at the LSB
    logic [W-1:0]  r_dvs;     // divisor magnitude
    logic [W:0]    r_rem;     // 17-bit partial remainder
    logic [CW-1:0] r_cnt;     // iteration counter
    logic          r_neg_q;   // quotient needs negation at the end
    logic          r_neg_r;   // remainder needs negation at the end

    // Combinational helpers
    logic          w_accept;
    logic          w_b_zero;
    logic          w_ovf_case;
    logic          w_special;
    logic          w_last;
    logic [W-1:0]  w_a_abs;
    logic [W-1:0]  w_b_abs;
    logic [W+1:0]  w_shift;
    logic [W+1:0]  w_trial;
    logic          w_qbit;
    logic [W:0]    w_rem_nx;
    logic [W-1:0]  w_quo_nx;
    logic [W-1:0]  w_q_fix;
    logic [W-1:0]  w_r_fix;
    logic          w_busy_nx;
    logic          w_done_nx;

    // Request qualification and special-case detection
    always_comb begin
        w_accept   = start && (r_state != S_CALC);
        w_b_zero   = (B == '0);
        w_ovf_case = signed_mode && (A == 16'h8000) && (B == 16'hFFFF);
        w_special  = w_b_zero || w_ovf_case;
        w_last     = (r_state == S_CALC) && (r_cnt == CW'(W - 1));
    end

    // Operand magnitudes; -32768 maps onto 16'h8000 which is correct unsigned
    always_comb begin
        w_a_abs = A;
        w_b_abs = B;
        if (signed_mode && A[W-1]) begin
            w_a_abs = W'(~A + W'(1));
        end
        if (signed_mode && B[W-1]) begin
            w_b_abs = W'(~B + W'(1));
        end
    end

    // One restoring step: shift in the next dividend bit, trial-subtract the
    // divisor, keep the difference when it does not borrow.
    always_comb begin
        w_shift  = {r_rem, r_dvd[W-1]};
        w_trial  = w_shift - (W + 2)'(r_dvs);
        w_qbit   = ~w_trial[W+1];
        w_rem_nx = w_qbit ? w_trial[W:0] : w_shift[W:0];
        w_quo_nx = {r_dvd[W-2:0], w_qbit};
    end

    // Final sign correction: truncation toward zero, remainder follows dividend
    always_comb begin
        w_q_fix = w_quo_nx;
        w_r_fix = w_rem_nx[W-1:0];
        if (r_neg_q) begin
            w_q_fix = W'(~w_quo_nx + W'(1));
        end
        if (r_neg_r) begin
            w_r_fix = W'(~w_rem_nx[W-1:0] + W'(1));
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_next = w_special ? S_DONE : S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state, registered below
    always_comb begin
        w_busy_nx = 1'b0;
        w_done_nx = 1'b0;
        case (w_next)
            S_CALC:  w_busy_nx = 1'b1;
            S_DONE:  w_done_nx = 1'b1;
            default: begin
                w_busy_nx = 1'b0;
                w_done_nx = 1'b0;
            end
        endcase
    end

    // Datapath, result and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            busy <= w_busy_nx;
            done <= w_done_nx;
            if (w_accept) begin
                r_dvd       <= w_a_abs;
                r_dvs       <= w_b_abs;
                r_rem       <= '0;
                r_cnt       <= '0;
                r_neg_q     <= signed_mode && (A[W-1] ^ B[W-1]);
                r_neg_r     <= signed_mode && A[W-1];
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
                if (w_b_zero) begin
                    quotient    <= 16'hFFFF;
                    remainder   <= A;
                    div_by_zero <= 1'b1;
                end else if (w_ovf_case) begin
                    quotient    <= 16'h8000;
                    remainder   <= '0;
                    overflow    <= 1'b1;
                end
            end else if (r_state == S_CALC) begin
                r_rem <= w_rem_nx;
                r_dvd <= w_quo_nx;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    quotient  <= w_q_fix;
                    remainder <= w_r_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_divide.sv
// tb_divide: directed-vector bench for the sequential divider.
module tb_divide;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    divide dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a one-cycle start at the current negedge; returns at the next negedge
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic sm);
        start       = 1'b1;
        A           = a;
        B           = b;
        signed_mode = sm;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting busy cycles; optionally pulse a stray start
    task automatic wait_done(input string tag, input logic [15:0] eq, input logic [15:0] er,
                             input logic edz, input logic eov, input int ebusy, input bit inject);
        int cyc = 0;
        int n   = 0;
        while (!done && n < 40) begin
            if (busy) cyc++;
            if (inject && n == 4) begin
                start       = 1'b1;
                A           = 16'h0032;
                B           = 16'h0005;
                signed_mode = 1'b1;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(cyc), 32'(ebusy));
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_quo"}, 32'(quotient), 32'(eq));
        chk({tag, "_rem"}, 32'(remainder), 32'(er));
        chk({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
        chk({tag, "_ov"}, 32'(overflow), 32'(eov));
    endtask

    // done must last exactly one cycle while results hold
    task automatic chk_drop(input string tag, input logic [15:0] eq, input logic [15:0] er);
        @(negedge clk);
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
        chk({tag, "_quo_hold"}, 32'(quotient), 32'(eq));
        chk({tag, "_rem_hold"}, 32'(remainder), 32'(er));
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        A           = '0;
        B           = '0;
        repeat (2) @(negedge clk);
        chk("rst_quo",  32'(quotient), 32'd0);
        chk("rst_rem",  32'(remainder), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dz",   32'(div_by_zero), 32'd0);
        chk("rst_ov",   32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned 100 / 7 = 14 r 2
        start_op(16'h0064, 16'h0007, 1'b0);
        wait_done("u100_7", 16'h000E, 16'h0002, 1'b0, 1'b0, 16, 1'b0);
        chk_drop("u100_7", 16'h000E, 16'h0002);

        // Signed -7 / 2 = -3 r -1
        start_op(16'hFFF9, 16'h0002, 1'b1);
        wait_done("s-7_2", 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 16, 1'b0);
        chk_drop("s-7_2", 16'hFFFD, 16'hFFFF);

        // Unsigned 65535 / 1
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done("uffff_1", 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16, 1'b0);
        chk_drop("uffff_1", 16'hFFFF, 16'h0000);

        // Signed 7 / -2 = -3 r 1
        start_op(16'h0007, 16'hFFFE, 1'b1);
        wait_done("s7_-2", 16'hFFFD, 16'h0001, 1'b0, 1'b0, 16, 1'b0);
        chk_drop("s7_-2", 16'hFFFD, 16'h0001);

        // Divide by zero: immediate DONE, busy never high
        start_op(16'h04D2, 16'h0000, 1'b0);
        wait_done("dz", 16'hFFFF, 16'h04D2, 1'b1, 1'b0, 0, 1'b0);
        chk_drop("dz", 16'hFFFF, 16'h04D2);

        // Signed overflow -32768 / -1
        start_op(16'h8000, 16'hFFFF, 1'b1);
        wait_done("sovf", 16'h8000, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
        chk_drop("sovf", 16'h8000, 16'h0000);

        // Same operands unsigned: 32768 / 65535 = 0 r 32768
        start_op(16'h8000, 16'hFFFF, 1'b0);
        wait_done("u8000_ffff", 16'h0000, 16'h8000, 1'b0, 1'b0, 16, 1'b0);
        chk_drop("u8000_ffff", 16'h0000, 16'h8000);

        // Stray start mid-CALC is ignored
        start_op(16'h0064, 16'h0007, 1'b0);
        wait_done("ignore", 16'h000E, 16'h0002, 1'b0, 1'b0, 16, 1'b1);
        chk_drop("ignore", 16'h000E, 16'h0002);

        // Back-to-back: new start on the done cycle
        start_op(16'h0064, 16'h0007, 1'b0);
        wait_done("b2b_1", 16'h000E, 16'h0002, 1'b0, 1'b0, 16, 1'b0);
        start_op(16'hFFF9, 16'h0002, 1'b1);
        chk("b2b_done_low", 32'(done), 32'd0);
        chk("b2b_busy_high", 32'(busy), 32'd1);
        wait_done("b2b_2", 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 16, 1'b0);
        chk_drop("b2b_2", 16'hFFFD, 16'hFFFF);

        // Asynchronous reset mid-CALC
        start_op(16'h0064, 16'h0007, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_quo",  32'(quotient), 32'd0);
        chk("arst_rem",  32'(remainder), 32'd0);
        chk("arst_dz",   32'(div_by_zero), 32'd0);
        chk("arst_ov",   32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fresh 50 / 5 after reset
        start_op(16'h0032, 16'h0005, 1'b0);
        wait_done("u50_5", 16'h000A, 16'h0000, 1'b0, 1'b0, 16, 1'b0);
        chk_drop("u50_5", 16'h000A, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
